multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter WID, default 64, operand width in bits (even, 8..128).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ld  in  1  start; sampled only in IDLE.
REQ-005 SHALL have port abort  in  1  cancel the operation in progress.
REQ-006 SHALL have port sgn  in  1  both operands two's complement; sampled with ld.
REQ-007 SHALL have port sgnus  in  1  a signed, b unsigned; sampled with ld; ignored when sgn=1.
REQ-008 SHALL have ports a, b  in  WID  multiplicand, multiplier.
REQ-009 SHALL have ports prodlo, prodhi  out  WID each  registered product, low and high halves.
REQ-010 SHALL have port done  out  1  equals (state==DONE) or (state==IDLE and ld==0).
REQ-011 SHALL have port idle  out  1  equals (state==IDLE).

Function
REQ-012 SHALL implement states IDLE, MUL and DONE; any other encoding SHALL go to IDLE on the next clock.
REQ-013 IDLE with ld=1 and abort=0 SHALL latch the operand magnitudes, set accumulator to 0 and cnt to the iteration count, and go to MUL.
REQ-014 The latched magnitudes SHALL be |a|,|b| with sign so=a[WID-1]^b[WID-1] when sgn=1, |a|,b with so=a[WID-1] when sgnus=1, and a,b with so=0 otherwise.
REQ-015 The magnitude of a most-negative operand SHALL be its bit pattern taken as unsigned (2^(WID-1)).
REQ-016 MUL with cnt!=0 SHALL do one shift-add step per clock and decrement cnt: radix-2 adds the multiplicand when the multiplier LSB is 1, then shifts the 2*WID-bit accumulator/multiplier right 1 bit.
REQ-017 MUL with cnt==0 SHALL write prodhi:prodlo = so ? -(magnitude product) : magnitude product, taken modulo 2^(2*WID), and go to DONE.
REQ-018 DONE SHALL last exactly one clock and then go to IDLE.
REQ-019 Latency SHALL be radix-2: ld accepted at edge N gives done=1 in state DONE after edge N+WID+2, with outputs valid from that same edge.
REQ-020 An ld asserted outside IDLE SHALL be ignored and SHALL NOT restart cnt.
REQ-021 abort=1 in MUL SHALL return to IDLE on the next edge, with prodlo/prodhi holding their prior values.
REQ-022 abort and ld both asserted in IDLE: abort SHALL win and the block SHALL stay IDLE.
REQ-023 abort in DONE SHALL have no effect, since the outputs are already written.
REQ-024 prodlo/prodhi SHALL change only on the MUL-to-DONE edge or on reset.
REQ-025 A back-to-back ld SHALL be accepted only in IDLE; minimum initiation interval is WID+3 clocks.

Reset
REQ-026 rst SHALL set state=IDLE, cnt=0, accumulator=0, prodlo=0 and prodhi=0, so idle=1 and done=!ld.
REQ-027 rst SHALL take priority over ld and abort, including mid-MUL, and the result SHALL be discarded.

Configuration
REQ-028 When MULTIPLIER_RADIX4_EN is defined, MUL SHALL retire 2 multiplier bits per clock by adding 0/1/2/3 times the multiplicand, with a 2*WID+2-bit accumulator.
REQ-029 With MULTIPLIER_RADIX4_EN defined, latency SHALL be WID/2+2 (done after edge N+WID/2+2).
REQ-030 When MULTIPLIER_RADIX4_EN is not defined, the radix-2 behaviour of REQ-016 and REQ-019 SHALL apply.
REQ-031 Product values and all handshake rules SHALL be identical in both configurations.

Verification (WID=64, radix-2 unless noted)
REQ-032 Unsigned: sgn=0, sgnus=0, a=10005, b=27, ld pulse -> prodlo=270135, prodhi=0, done rises exactly 66 clocks after ld edge.
REQ-033 Signed: sgn=1, a=-10005, b=27 -> prodhi=0xFFFFFFFFFFFFFFFF, prodlo=0xFFFFFFFFFFFBE0C9 (-270135).
REQ-034 Mixed: sgnus=1, a=-1, b=0xFFFFFFFFFFFFFFFF -> prodhi=0xFFFFFFFFFFFFFFFF, prodlo=0x0000000000000001; unsigned max sgn=0 a=b=0xFFFFFFFFFFFFFFFF -> prodhi=0xFFFFFFFFFFFFFFFE, prodlo=1.
REQ-035 Abort: start 7*9, assert abort 10 clocks later -> idle=1 next clock, outputs keep prior result; second ld with ld held through MUL -> one operation only.
REQ-036 Reset mid-op: rst at clock 20 of MUL -> state IDLE, prodlo=prodhi=0, no DONE pulse.
REQ-037 With MULTIPLIER_RADIX4_EN defined, rerunning REQ-032..034 -> identical products, done 34 clocks after ld edge.

Source files
------------

// File: rtl/multiplier.sv
// Sequential shift-add multiplier with signed / mixed / unsigned operand modes.
// Defining MULTIPLIER_RADIX4_EN retires two multiplier bits per clock instead of one.
module multiplier #(
  parameter int WID = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           abort,
  input  logic           sgn,
  input  logic           sgnus,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic [WID-1:0] prodlo,
  output logic [WID-1:0] prodhi,
  output logic           done,
  output logic           idle
);

`ifdef MULTIPLIER_RADIX4_EN
  localparam int R = 2;
`else
  localparam int R = 1;
`endif
  localparam int ITER  = WID / R;
  localparam int HI_W  = WID + 2 * (R - 1);
  localparam int CNT_W = $clog2(ITER + 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic [WID-1:0]   lo_q, lo_d;
  logic [WID-1:0]   mc_q, mc_d;
  logic             so_q, so_d;
  logic [WID-1:0]   prodlo_q, prodlo_d;
  logic [WID-1:0]   prodhi_q, prodhi_d;

  logic [WID-1:0]   mag_a, mag_b;
  logic             so_in;
  logic [WID+1:0]   addend, sum;
  logic [HI_W-1:0]  hi_step;
  logic [WID-1:0]   lo_step;
  logic [2*WID-1:0] mag_prod, prod_fin;

  // Negating the most-negative pattern yields itself, which read unsigned is 2^(WID-1).
  always_comb begin
    mag_a = ((sgn || sgnus) && a[WID-1]) ? -a : a;
    mag_b = (sgn && b[WID-1]) ? -b : b;
    so_in = sgn ? (a[WID-1] ^ b[WID-1]) : (sgnus ? a[WID-1] : 1'b0);
  end

  always_comb begin
    addend = lo_q[0] ? (WID+2)'(mc_q) : '0;
    if (R == 2 && lo_q[1]) addend = addend + ((WID+2)'(mc_q) << 1);
    sum      = (WID+2)'(hi_q) + addend;
    hi_step  = HI_W'(sum >> R);
    lo_step  = {sum[R-1:0], lo_q[WID-1:R]};
    mag_prod = {hi_q[WID-1:0], lo_q};
    prod_fin = so_q ? -mag_prod : mag_prod;
  end

  // cnt starts one above the step count; that first MUL clock only lets operands settle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    so_d     = so_q;
    prodlo_d = prodlo_q;
    prodhi_d = prodhi_q;
    case (state_q)
      IDLE: if (ld && !abort) begin
        state_d = MUL;
        cnt_d   = CNT_INIT;
        hi_d    = '0;
        lo_d    = mag_b;
        mc_d    = mag_a;
        so_d    = so_in;
      end
      MUL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          {prodhi_d, prodlo_d} = prod_fin;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q != CNT_INIT) begin
            hi_d = hi_step;
            lo_d = lo_step;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      so_q     <= 1'b0;
      prodlo_q <= '0;
      prodhi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      so_q     <= so_d;
      prodlo_q <= prodlo_d;
      prodhi_q <= prodhi_d;
    end
  end

  assign prodlo = prodlo_q;
  assign prodhi = prodhi_q;
  assign idle   = (state_q == IDLE);
  assign done   = (state_q == DONE) || ((state_q == IDLE) && !ld);

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for multiplier (WID=64); latency expectation follows MULTIPLIER_RADIX4_EN.
module tb_multiplier;
  localparam int WID = 64;
`ifdef MULTIPLIER_RADIX4_EN
  localparam int LAT = WID / 2 + 2;
`else
  localparam int LAT = WID + 2;
`endif

  logic           clk = 1'b0;
  logic           rst, ld, abort, sgn, sgnus;
  logic [WID-1:0] a, b, prodlo, prodhi;
  logic           done, idle;
  int             nvec = 0;
  int             nerr = 0;

  multiplier #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .ld(ld), .abort(abort), .sgn(sgn), .sgnus(sgnus),
    .a(a), .b(b), .prodlo(prodlo), .prodhi(prodhi), .done(done), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one ld pulse (ld left high when hold=1); returns just after the accepting edge.
  task automatic start_op(input logic [WID-1:0] ta, input logic [WID-1:0] tb, input logic s,
                          input logic su, input bit hold);
    a = ta; b = tb; sgn = s; sgnus = su; ld = 1'b1;
    tick();
    if (!hold) ld = 1'b0;
  endtask

  // Counts edges until the DONE state is seen; -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done && !idle) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; abort = 1'b0; sgn = 1'b0; sgnus = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    nvec++; if (prodlo !== 64'd0 || prodhi !== 64'd0) begin
      nerr++; $display("FAIL reset_prod got %h_%h want 0", prodhi, prodlo); end
    nvec++; if (idle !== 1'b1 || done !== 1'b1) begin
      nerr++; $display("FAIL reset_flags got idle=%b done=%b want 1 1", idle, done); end
    ld = 1'b1; abort = 1'b1; #1;
    nvec++; if (done !== 1'b0) begin
      nerr++; $display("FAIL idle_ld_done got %b want 0", done); end
    tick();
    nvec++; if (idle !== 1'b1 || prodlo !== 64'd0) begin
      nerr++; $display("FAIL abort_beats_ld got idle=%b lo=%h want 1 0", idle, prodlo); end
    ld = 1'b0; abort = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    start_op(64'd10005, 64'd27, 1'b0, 1'b0, 1'b0);
    nvec++; if (idle !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL busy_flags got idle=%b done=%b want 0 0", idle, done); end
    wait_done(lat);
    nvec++; if (lat !== LAT) begin
      nerr++; $display("FAIL unsigned_latency got %0d want %0d", lat, LAT); end
    nvec++; if (prodlo !== 64'd270135 || prodhi !== 64'd0) begin
      nerr++; $display("FAIL unsigned_prod got %h_%h want 0_41f37", prodhi, prodlo); end
    tick();
    nvec++; if (idle !== 1'b1 || done !== 1'b1) begin
      nerr++; $display("FAIL done_one_clock got idle=%b done=%b want 1 1", idle, done); end
  endtask

  task automatic test_signed();
    int lat;
    start_op(-64'sd10005, 64'd27, 1'b1, 1'b0, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'hFFFFFFFFFFFBE0C9 || prodhi !== 64'hFFFFFFFFFFFFFFFF || lat !== LAT) begin
      nerr++; $display("FAIL signed_neg got %h_%h lat %0d", prodhi, prodlo, lat); end
    tick();
    start_op(64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b0, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'd0 || prodhi !== 64'h4000000000000000) begin
      nerr++; $display("FAIL signed_minmin got %h_%h want 4000000000000000_0", prodhi, prodlo); end
    tick();
    start_op(64'h8000000000000000, 64'd1, 1'b1, 1'b0, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'h8000000000000000 || prodhi !== 64'hFFFFFFFFFFFFFFFF) begin
      nerr++; $display("FAIL signed_min_x1 got %h_%h", prodhi, prodlo); end
    tick();
    start_op(-64'sd3, -64'sd5, 1'b1, 1'b1, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'd15 || prodhi !== 64'd0) begin
      nerr++; $display("FAIL signed_negneg got %h_%h want 0_f", prodhi, prodlo); end
    tick();
  endtask

  task automatic test_mixed();
    int lat;
    start_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'd1 || prodhi !== 64'hFFFFFFFFFFFFFFFF || lat !== LAT) begin
      nerr++; $display("FAIL mixed got %h_%h lat %0d", prodhi, prodlo, lat); end
    tick();
    start_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    nvec++; if (prodlo !== 64'd1 || prodhi !== 64'hFFFFFFFFFFFFFFFE) begin
      nerr++; $display("FAIL unsigned_max got %h_%h want fffffffffffffffe_1", prodhi, prodlo); end
    tick();
  endtask

  task automatic test_abort();
    start_op(64'd7, 64'd9, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nvec++; if (idle !== 1'b1) begin
      nerr++; $display("FAIL abort_idle got %b want 1", idle); end
    nvec++; if (prodlo !== 64'd1 || prodhi !== 64'hFFFFFFFFFFFFFFFE) begin
      nerr++; $display("FAIL abort_hold got %h_%h want fffffffffffffffe_1", prodhi, prodlo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(64'd7, 64'd9, 1'b0, 1'b0, 1'b1);
    a = 64'd100;
    wait_done(lat);
    ld = 1'b0;
    abort = 1'b1;
    nvec++; if (lat !== LAT || prodlo !== 64'd63 || prodhi !== 64'd0) begin
      nerr++; $display("FAIL ld_held got %h_%h lat %0d want 0_3f lat %0d", prodhi, prodlo, lat, LAT); end
    tick();
    abort = 1'b0;
    nvec++; if (idle !== 1'b1 || prodlo !== 64'd63) begin
      nerr++; $display("FAIL abort_in_done got idle=%b lo=%h want 1 3f", idle, prodlo); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    start_op(64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (idle !== 1'b1 || prodlo !== 64'd0 || prodhi !== 64'd0) begin
      nerr++; $display("FAIL reset_mid got idle=%b %h_%h want 1 0_0", idle, prodhi, prodlo); end
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done && !idle) seen++;
    end
    nvec++; if (seen !== 0) begin
      nerr++; $display("FAIL reset_mid_no_done got %0d done pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
